// File: rtl/alu_result_register_pkg.sv
// Shared definitions for the ALU result stage: default geometry and FSM state encoding.
package alu_result_register_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        STATE_LIVE   = 1'b0,
        STATE_REVIEW = 1'b1
    } state_e;

endpackage

// File: rtl/alu_result_register_hist_ring_buffer.sv
// History ring buffer: circular storage of the last DEPTH results, occupancy tracking,
// sticky overflow, and a read port addressed by age (0 = newest).
module hist_ring_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_age_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             full_w;
    logic [AW-1:0]    rd_idx_w;

    assign full_w = (count_q == CW'(DEPTH));

    // DEPTH is a power of two, so the pointer wraps naturally at DEPTH-1 -> 0.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (full_w) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; entries beyond count are never presented.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_idx_w   = wr_ptr_q - AW'(1) - rd_age_i;
    assign rd_data_o  = (count_q == '0) ? '0 : mem_q[rd_idx_w];
    assign count_o    = count_q;
    assign full_o     = full_w;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/alu_result_register.sv
// ALU result stage: accept handshake, held Result/FeedbackB, review-mode FSM
// that steps through the result history for display.
module alu_result_register
    import alu_result_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   ALUout,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic               review,
    output logic [WIDTH-1:0]   Result,
    output logic [WIDTH/2-1:0] FeedbackB,
    output logic [WIDTH-1:0]   HistOut,
    output logic [AW-1:0]      HistAge,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               overflow
);

    state_e           state_q;
    logic             alu_ready_q;
    logic [AW-1:0]    hist_age_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             review_q;
    logic             review_edge_w;
    logic             accept_w;
    logic [CW-1:0]    count_w;
    logic             last_age_w;

    assign review_edge_w = review & ~review_q;
    assign accept_w      = alu_valid & alu_ready_q;
    assign result_d      = accept_w ? ALUout : result_q;
    assign last_age_w    = ({1'b0, hist_age_q} == (count_w - CW'(1)));

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            review_q <= 1'b0;
            result_q <= '0;
        end else begin
            review_q <= review;
            result_q <= result_d;
        end
    end

    // A review edge coinciding with an accept still enters REVIEW: the write lands
    // first, so age 0 then shows the freshly captured result.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q     <= STATE_LIVE;
            alu_ready_q <= 1'b1;
            hist_age_q  <= '0;
        end else begin
            case (state_q)
                STATE_LIVE: begin
                    if (review_edge_w && (count_w != '0 || accept_w)) begin
                        state_q     <= STATE_REVIEW;
                        alu_ready_q <= 1'b0;
                        hist_age_q  <= '0;
                    end
                end
                STATE_REVIEW: begin
                    if (review_edge_w) begin
                        if (last_age_w) begin
                            state_q     <= STATE_LIVE;
                            alu_ready_q <= 1'b1;
                            hist_age_q  <= '0;
                        end else begin
                            hist_age_q <= hist_age_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= STATE_LIVE;
                    alu_ready_q <= 1'b1;
                    hist_age_q  <= '0;
                end
            endcase
        end
    end

    hist_ring_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk        (CLOCK_50),
        .srst       (Reset),
        .wr_en_i    (accept_w),
        .wr_data_i  (ALUout),
        .rd_age_i   (hist_age_q),
        .rd_data_o  (HistOut),
        .count_o    (count_w),
        .full_o     (full),
        .overflow_o (overflow)
    );

    assign alu_ready = alu_ready_q;
    assign Result    = result_q;
    assign FeedbackB = result_q[WIDTH/2-1:0];
    assign HistAge   = hist_age_q;
    assign count     = count_w;

endmodule

// File: tb/tb_alu_result_register.sv
// Directed bench for alu_result_register (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_alu_result_register;

    logic       CLOCK_50;
    logic       Reset;
    logic [7:0] ALUout;
    logic       alu_valid;
    logic       alu_ready;
    logic       review;
    logic [7:0] Result;
    logic [3:0] FeedbackB;
    logic [7:0] HistOut;
    logic [1:0] HistAge;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int checks_total;
    int checks_passed;

    alu_result_register #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .ALUout    (ALUout),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .review    (review),
        .Result    (Result),
        .FeedbackB (FeedbackB),
        .HistOut   (HistOut),
        .HistAge   (HistAge),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
            $display("check %-16s observed=%0h expected=%0h ok", tag, observed, expected);
        end else begin
            $display("FAIL %-16s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic accept(input logic [7:0] v);
        ALUout    = v;
        alu_valid = 1'b1;
        step();
        alu_valid = 1'b0;
        ALUout    = 8'h00;
    endtask

    task automatic review_pulse();
        review = 1'b1;
        step();
        review = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_result"},   32'(Result),    32'h00);
        check({pfx, "_fbb"},      32'(FeedbackB), 32'h0);
        check({pfx, "_count"},    32'(count),     32'd0);
        check({pfx, "_full"},     32'(full),      32'd0);
        check({pfx, "_overflow"}, 32'(overflow),  32'd0);
        check({pfx, "_histage"},  32'(HistAge),   32'd0);
        check({pfx, "_histout"},  32'(HistOut),   32'h00);
        check({pfx, "_ready"},    32'(alu_ready), 32'd1);
    endtask

    logic [7:0] hist_exp [4];

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        Reset     = 1'b1;
        ALUout    = 8'h00;
        alu_valid = 1'b0;
        review    = 1'b0;
        step();
        step();
        Reset = 1'b0;
        check_all_zero("rst");

        // Review edge on an empty history is ignored
        review_pulse();
        check("empty_rev_ready", 32'(alu_ready), 32'd1);
        check("empty_rev_age",   32'(HistAge),   32'd0);

        // Test 1: single capture
        accept(8'h3C);
        check("t1_result",  32'(Result),    32'h3C);
        check("t1_fbb",     32'(FeedbackB), 32'hC);
        check("t1_count",   32'(count),     32'd1);
        check("t1_histout", 32'(HistOut),   32'h3C);
        check("t1_full",    32'(full),      32'd0);

        // Test 2: overfill a 4-deep history
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            accept(8'(i));
            check("t2_result", 32'(Result), 32'(i));
        end
        check("t2_full",     32'(full),     32'd1);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_count",    32'(count),    32'd4);
        check("t2_histout",  32'(HistOut),  32'h05);

        // Test 3: walk the history newest to oldest, then back to LIVE
        hist_exp[0] = 8'h05; hist_exp[1] = 8'h04; hist_exp[2] = 8'h03; hist_exp[3] = 8'h02;
        for (int a = 0; a < 4; a++) begin
            review_pulse();
            check("t3_ready",   32'(alu_ready), 32'd0);
            check("t3_age",     32'(HistAge),   32'(a));
            check("t3_histout", 32'(HistOut),   32'(hist_exp[a]));
        end
        review_pulse();
        check("t3_live_ready", 32'(alu_ready), 32'd1);
        check("t3_live_age",   32'(HistAge),   32'd0);
        check("t3_live_hist",  32'(HistOut),   32'h05);

        // Test 4: captures are dropped while reviewing
        review_pulse();
        check("t4_ready", 32'(alu_ready), 32'd0);
        accept(8'hFF);
        check("t4_result",  32'(Result),  32'h05);
        check("t4_count",   32'(count),   32'd4);
        check("t4_histout", 32'(HistOut), 32'h05);
        for (int a = 1; a < 4; a++) begin
            review_pulse();
            check("t4_hist", 32'(HistOut), 32'(hist_exp[a]));
        end
        review_pulse();
        check("t4_live_ready", 32'(alu_ready), 32'd1);
        check("t4_live_hist",  32'(HistOut),   32'h05);

        // Test 5: accept and review edge in the same cycle
        ALUout    = 8'hA5;
        alu_valid = 1'b1;
        review    = 1'b1;
        step();
        alu_valid = 1'b0;
        review    = 1'b0;
        ALUout    = 8'h00;
        step();
        check("t5_ready",   32'(alu_ready), 32'd0);
        check("t5_age",     32'(HistAge),   32'd0);
        check("t5_histout", 32'(HistOut),   32'hA5);
        check("t5_result",  32'(Result),    32'hA5);
        check("t5_fbb",     32'(FeedbackB), 32'h5);
        review_pulse();
        check("t5_age1",    32'(HistOut),   32'h05);

        // Test 6: reset while reviewing with three entries
        do_reset();
        accept(8'h11);
        accept(8'h22);
        accept(8'h33);
        check("t6_count", 32'(count), 32'd3);
        review_pulse();
        review_pulse();
        check("t6_rev_age",  32'(HistAge),   32'd1);
        check("t6_rev_hist", 32'(HistOut),   32'h22);
        check("t6_rev_rdy",  32'(alu_ready), 32'd0);
        do_reset();
        check_all_zero("t6");

        // Stage is live again after the mid-review reset
        accept(8'h77);
        check("t6_post_res",   32'(Result),  32'h77);
        check("t6_post_count", 32'(count),   32'd1);
        check("t6_post_hist",  32'(HistOut), 32'h77);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
